// File: rtl/rx_parse_arb.sv
// Two-port RX arbiter feeding one shared header parser.
// A tag FIFO remembers each packet's source port until the parser reports its metadata.
module rx_parse_arb #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  s0_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
    input  logic                  s0_axis_tlast,
    input  logic [15:0]           s0_axis_tuser_size,
    output logic                  s0_axis_tready,

    input  logic                  s1_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
    input  logic                  s1_axis_tlast,
    input  logic [15:0]           s1_axis_tuser_size,
    output logic                  s1_axis_tready,

    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [15:0]           m_axis_tuser_size,
    output logic                  m_axis_tuser_port,
    input  logic                  m_axis_tready,

    input  logic                  parser_meta_valid,
    output logic                  meta_port_valid,
    output logic                  meta_port,

    output logic [31:0]           pkt_cnt0,
    output logic [31:0]           pkt_cnt1,
    output logic                  err_tag_underflow
);

    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(TAG_DEPTH);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          gnt;
    logic          gnt_nxt;
    logic          last_gnt;
    logic          pick;
    logic          push;
    logic          pop;
    logic          done;
    logic          full;
    logic          empty;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          tag_mem [TAG_DEPTH];

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign pop   = parser_meta_valid && !empty;

    // Round robin only matters on a tie; a lone requester always wins.
    assign pick = (s0_axis_tvalid && s1_axis_tvalid) ? ~last_gnt
                                                      : s1_axis_tvalid;

    always_comb begin
        state_nxt         = state;
        gnt_nxt           = gnt;
        push              = 1'b0;
        done              = 1'b0;
        m_axis_tvalid     = 1'b0;
        m_axis_tdata      = '0;
        m_axis_tkeep      = '0;
        m_axis_tlast      = 1'b0;
        m_axis_tuser_size = '0;
        m_axis_tuser_port = 1'b0;
        s0_axis_tready    = 1'b0;
        s1_axis_tready    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!full && (s0_axis_tvalid || s1_axis_tvalid)) begin
                    gnt_nxt   = pick;
                    push      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                m_axis_tuser_port = gnt;
                if (gnt) begin
                    m_axis_tvalid     = s1_axis_tvalid;
                    m_axis_tdata      = s1_axis_tdata;
                    m_axis_tkeep      = s1_axis_tkeep;
                    m_axis_tlast      = s1_axis_tlast;
                    m_axis_tuser_size = s1_axis_tuser_size;
                    s1_axis_tready    = m_axis_tready;
                end else begin
                    m_axis_tvalid     = s0_axis_tvalid;
                    m_axis_tdata      = s0_axis_tdata;
                    m_axis_tkeep      = s0_axis_tkeep;
                    m_axis_tlast      = s0_axis_tlast;
                    m_axis_tuser_size = s0_axis_tuser_size;
                    s0_axis_tready    = m_axis_tready;
                end
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            if (done) begin
                last_gnt <= gnt;
                if (gnt) pkt_cnt1 <= pkt_cnt1 + 32'd1;
                else     pkt_cnt0 <= pkt_cnt0 + 32'd1;
            end
        end
    end

    // Tag storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= gnt_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            meta_port_valid   <= 1'b0;
            meta_port         <= 1'b0;
            err_tag_underflow <= 1'b0;
        end else begin
            meta_port_valid <= pop;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                meta_port <= tag_mem[rd_ptr];
            end
            unique case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
            if (parser_meta_valid && empty) err_tag_underflow <= 1'b1;
        end
    end

endmodule

// File: doc/rx_parse_arb.md
RX_PARSE_ARB -- requirements
Module: rx_parse_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, meaning stream data width in bits.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, meaning byte-enable width.
REQ-003 SHALL have parameter TAG_DEPTH, default 4, meaning port-tag FIFO depth (power of 2, >=2).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s0_axis_tvalid/tdata/tkeep/tlast/tuser_size  input  1/DATA_WIDTH/KEEP_WIDTH/1/16  RX port 0 stream.
REQ-007 s0_axis_tready  output  1  port 0 ready.
REQ-008 s1_axis_tvalid/tdata/tkeep/tlast/tuser_size  input  1/DATA_WIDTH/KEEP_WIDTH/1/16  RX port 1 stream.
REQ-009 s1_axis_tready  output  1  port 1 ready.
REQ-010 m_axis_tvalid/tdata/tkeep/tlast/tuser_size  output  1/DATA_WIDTH/KEEP_WIDTH/1/16  stream to shared header parser.
REQ-011 m_axis_tuser_port  output  1  source port of the current beat.
REQ-012 m_axis_tready  input  1  parser ready.
REQ-013 parser_meta_valid  input  1  one-cycle pulse from parser, one per packet, in packet order.
REQ-014 meta_port_valid  output  1  registered copy of parser_meta_valid when a tag is popped.
REQ-015 meta_port  output  1  source port matching the parser metadata of that cycle.
REQ-016 pkt_cnt0, pkt_cnt1  output  32 each  packets completed per port.
REQ-017 err_tag_underflow  output  1  sticky: metadata arrived with no outstanding tag.

Function
REQ-018 FSM SHALL have two states: IDLE and BUSY, plus a registered grant index gnt and round-robin pointer last_gnt.
REQ-019 In IDLE, all s*_axis_tready SHALL be 0 and m_axis_tvalid SHALL be 0.
REQ-020 In IDLE, when tag FIFO not full and at least one s*_axis_tvalid=1, the FSM SHALL register gnt and move to BUSY next cycle.
REQ-021 Grant selection: only one port valid -> that port; both valid -> port != last_gnt.
REQ-022 On the IDLE->BUSY transition cycle, gnt SHALL be pushed into the tag FIFO.
REQ-023 In BUSY, m_axis_* SHALL combinationally equal the granted s*_axis_* and m_axis_tuser_port=gnt; granted tready SHALL equal m_axis_tready; the other tready SHALL be 0.
REQ-024 A beat SHALL never be dropped, duplicated or reordered; a granted packet SHALL never be interrupted.
REQ-025 On m_axis handshake with tlast=1, FSM SHALL return to IDLE, set last_gnt=gnt, and increment the granted port's counter by 1 (wrap 0xFFFFFFFF->0).
REQ-026 Inter-packet gap SHALL be exactly one cycle (the IDLE grant cycle).
REQ-027 Tag FIFO full (TAG_DEPTH outstanding tags) SHALL hold FSM in IDLE; it SHALL NOT affect a packet already in BUSY.
REQ-028 On parser_meta_valid with FIFO non-empty: pop head; next cycle meta_port_valid=1, meta_port=popped tag (latency 1).
REQ-029 Simultaneous push and pop SHALL leave occupancy unchanged; FIFO pointers wrap modulo TAG_DEPTH.
REQ-030 On parser_meta_valid with FIFO empty (occupancy sampled before the cycle's push): no pop, meta_port_valid=0, err_tag_underflow<=1 (sticky until reset).
REQ-031 meta_port_valid SHALL be a single-cycle pulse per pop.

Reset
REQ-032 rst_n=0 SHALL immediately force: FSM=IDLE, gnt=0, last_gnt=1 (port 0 wins first tie), FIFO empty, meta_port_valid=0, meta_port=0, pkt_cnt0=pkt_cnt1=0, err_tag_underflow=0, all tready=0, m_axis_tvalid=0.
REQ-033 Reset asserted mid-packet SHALL abandon the packet; no counter increment; the remaining beats after release are treated as a new packet.

Verification
REQ-034 Both ports continuously valid with 3-beat packets, m_axis_tready=1 -> grants 0,1,0,1; each packet 3 beats + 1 gap cycle; after 4 packets pkt_cnt0=2, pkt_cnt1=2.
REQ-035 Port 1 only, m_axis_tready toggling 1/0 mid-packet -> beats forwarded in order, s1_axis_tready mirrors m_axis_tready, s0_axis_tready=0 throughout, m_axis_tuser_port=1.
REQ-036 Five single-beat packets from port 0, no parser_meta_valid -> four forwarded, fifth held (s0_axis_tready=0) until one parser_meta_valid, then meta_port_valid=1, meta_port=0 one cycle later and fifth packet granted.
REQ-037 parser_meta_valid with no packet ever sent -> err_tag_underflow=1 next cycle and stays 1; meta_port_valid=0.
REQ-038 rst_n low during beat 2 of a 4-beat port-0 packet -> all outputs at reset values asynchronously; pkt_cnt0=0 after release.
REQ-039 pkt_cnt1 preset by forcing to 0xFFFFFFFF, one port-1 packet completes -> pkt_cnt1=0.
